rr_find_first_set: RTL and testbench



---
 rtl/rr_find_first_set_pkg.sv | 9 +
 rtl/rr_find_first_set_ffs.sv | 24 ++
 rtl/rr_find_first_set.sv | 102 ++++++++++
 tb/tb_rr_find_first_set.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_find_first_set_pkg.sv
// Shared types for the round-robin find-first-set block.
package rr_find_first_set_pkg;

   typedef enum logic {
      FFS_FIXED = 1'b0,
      FFS_RR    = 1'b1
   } ffs_mode_t;

endpackage

// File: rtl/rr_find_first_set_ffs.sv
// Combinational find-first-set: index of the lowest set bit, or N when none is set.
module find_first_set #(
   parameter int LG_N = 3
) (
   input  logic [(1<<LG_N)-1:0] in,
   output logic [LG_N:0]        y
);

   localparam int unsigned N = 1 << LG_N;

   logic found;

   always_comb begin
      y     = (LG_N+1)'(N);
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && in[i]) begin
            y     = (LG_N+1)'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_find_first_set.sv
// Registered find-first-set with fixed or rotating priority and a one-entry
// valid/ready output stage.
module rr_find_first_set #(
   parameter int LG_N       = 3,
   parameter bit RR_DEFAULT = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 mode_rr,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [(1<<LG_N)-1:0] in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LG_N:0]        out_y,
   output logic [(1<<LG_N)-1:0] out_onehot,
   output logic [LG_N-1:0]      ptr
);

   import rr_find_first_set_pkg::*;

   localparam int unsigned   N    = 1 << LG_N;
   localparam logic [LG_N:0] NONE = (LG_N+1)'(N);

   logic            valid_q, valid_d;
   logic [LG_N:0]   y_q,     y_d;
   logic [LG_N-1:0] ptr_q,   ptr_d;
   ffs_mode_t       mode_q,  mode_d;

   logic            accept;
   logic [N-1:0]    lo_mask;
   logic [N-1:0]    masked;
   logic [LG_N:0]   y_masked;
   logic [LG_N:0]   y_full;
   logic [LG_N:0]   sel_y;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Mode bit follows mode_rr on every accept; selection only matters then.
   assign mode_d   = accept ? ffs_mode_t'(mode_rr) : mode_q;

   // Bits at or above the pointer take priority; the full search covers wrap-around.
   assign lo_mask  = {N{1'b1}} << ptr_q;
   assign masked   = in & lo_mask;

   find_first_set #(.LG_N(LG_N)) u_ffs_masked (
      .in (masked),
      .y  (y_masked)
   );

   find_first_set #(.LG_N(LG_N)) u_ffs_full (
      .in (in),
      .y  (y_full)
   );

   always_comb begin
      sel_y = y_full;
      if (mode_d == FFS_RR && masked != '0) begin
         sel_y = y_masked;
      end
   end

   // Flush wins over a same-cycle accept, discarding its pointer update too.
   always_comb begin
      valid_d = valid_q;
      y_d     = y_q;
      ptr_d   = ptr_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         y_d     = sel_y;
         if (mode_d == FFS_RR && in != '0) begin
            ptr_d = sel_y[LG_N-1:0] + LG_N'(1);
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         y_q     <= NONE;
         ptr_q   <= '0;
         mode_q  <= ffs_mode_t'(RR_DEFAULT);
      end else begin
         valid_q <= valid_d;
         y_q     <= y_d;
         ptr_q   <= ptr_d;
         mode_q  <= mode_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_y      = y_q;
   assign ptr        = ptr_q;
   assign out_onehot = (y_q == NONE) ? '0 : (N'(1) << y_q[LG_N-1:0]);

endmodule

// File: tb/tb_rr_find_first_set.sv
// Directed-vector bench for rr_find_first_set with LG_N = 3.
module tb_rr_find_first_set;

   logic       clk = 1'b0;
   logic       reset, flush, mode_rr, in_valid, out_ready;
   logic [7:0] din;
   logic       in_ready, out_valid;
   logic [3:0] out_y;
   logic [7:0] out_onehot;
   logic [2:0] ptr;

   int checks = 0;
   int errors = 0;

   rr_find_first_set #(.LG_N(3), .RR_DEFAULT(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .mode_rr    (mode_rr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in         (din),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_onehot (out_onehot),
      .ptr        (ptr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
      checks++; if (out_y !== 4'd8) begin errors++; $display("FAIL reset_y got %0d exp 8", out_y); end
      checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h exp 00", out_onehot); end
      checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", ptr); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", in_ready); end
   endtask

   task automatic test_fixed();
      mode_rr = 1'b0; din = 8'b0010_1000; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid got %0d exp 1", out_valid); end
      checks++; if (out_y !== 4'd3) begin errors++; $display("FAIL fixed_y got %0d exp 3", out_y); end
      checks++; if (out_onehot !== 8'h08) begin errors++; $display("FAIL fixed_onehot got %h exp 08", out_onehot); end
      checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL fixed_ptr got %0d exp 0", ptr); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got %0d exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      mode_rr = 1'b1; din = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         checks++; if (out_y !== 4'(i % 8)) begin errors++; $display("FAIL sweep_y[%0d] got %0d exp %0d", i, out_y, i % 8); end
         checks++; if (ptr !== 3'((i + 1) % 8)) begin errors++; $display("FAIL sweep_ptr[%0d] got %0d exp %0d", i, ptr, (i + 1) % 8); end
      end
      in_valid = 1'b0;
      checks++; if (ptr !== 3'd1) begin errors++; $display("FAIL sweep_ptr_end got %0d exp 1", ptr); end
      step();
   endtask

   task automatic test_rr_wrap();
      mode_rr = 1'b1; din = 8'b0010_0000; in_valid = 1'b1; out_ready = 1'b1;
      step();
      checks++; if (out_y !== 4'd5) begin errors++; $display("FAIL wrap_setup_y got %0d exp 5", out_y); end
      checks++; if (ptr !== 3'd6) begin errors++; $display("FAIL wrap_setup_ptr got %0d exp 6", ptr); end
      din = 8'b0000_0101;
      step();
      checks++; if (out_y !== 4'd0) begin errors++; $display("FAIL wrap1_y got %0d exp 0", out_y); end
      checks++; if (ptr !== 3'd1) begin errors++; $display("FAIL wrap1_ptr got %0d exp 1", ptr); end
      step();
      in_valid = 1'b0;
      checks++; if (out_y !== 4'd2) begin errors++; $display("FAIL wrap2_y got %0d exp 2", out_y); end
      checks++; if (ptr !== 3'd3) begin errors++; $display("FAIL wrap2_ptr got %0d exp 3", ptr); end
      step();
   endtask

   task automatic test_zero();
      mode_rr = 1'b1; din = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0d exp 1", out_valid); end
      checks++; if (out_y !== 4'd8) begin errors++; $display("FAIL zero_y got %0d exp 8", out_y); end
      checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL zero_onehot got %h exp 00", out_onehot); end
      checks++; if (ptr !== 3'd3) begin errors++; $display("FAIL zero_ptr got %0d exp 3", ptr); end
      step();
   endtask

   task automatic test_backpressure();
      mode_rr = 1'b1; din = 8'h02; in_valid = 1'b1; out_ready = 1'b0;
      step();
      din = 8'h10;
      checks++; if (out_y !== 4'd1) begin errors++; $display("FAIL bp_load_y got %0d exp 1", out_y); end
      checks++; if (ptr !== 3'd2) begin errors++; $display("FAIL bp_load_ptr got %0d exp 2", ptr); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_load_in_ready got %0d exp 0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0d exp 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0d exp 1", i, out_valid); end
         checks++; if (out_y !== 4'd1) begin errors++; $display("FAIL bp_y[%0d] got %0d exp 1", i, out_y); end
         checks++; if (out_onehot !== 8'h02) begin errors++; $display("FAIL bp_onehot[%0d] got %h exp 02", i, out_onehot); end
         checks++; if (ptr !== 3'd2) begin errors++; $display("FAIL bp_ptr[%0d] got %0d exp 2", i, ptr); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %0d exp 1", in_ready); end
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reload_valid got %0d exp 1", out_valid); end
      checks++; if (out_y !== 4'd4) begin errors++; $display("FAIL bp_reload_y got %0d exp 4", out_y); end
      checks++; if (out_onehot !== 8'h10) begin errors++; $display("FAIL bp_reload_onehot got %h exp 10", out_onehot); end
      checks++; if (ptr !== 3'd5) begin errors++; $display("FAIL bp_reload_ptr got %0d exp 5", ptr); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1; in_valid = 1'b1; din = 8'h01; out_ready = 1'b1; mode_rr = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0d exp 0", out_valid); end
      checks++; if (out_y !== 4'd8) begin errors++; $display("FAIL rstmid_y got %0d exp 8", out_y); end
      checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL rstmid_onehot got %h exp 00", out_onehot); end
      checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL rstmid_ptr got %0d exp 0", ptr); end
   endtask

   task automatic test_flush_mid();
      mode_rr = 1'b1; din = 8'h10; in_valid = 1'b1; out_ready = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup_valid got %0d exp 1", out_valid); end
      checks++; if (ptr !== 3'd5) begin errors++; $display("FAIL flush_setup_ptr got %0d exp 5", ptr); end
      flush = 1'b1; out_ready = 1'b1; din = 8'h80;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0d exp 1", in_ready); end
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0d exp 0", out_valid); end
      checks++; if (ptr !== 3'd5) begin errors++; $display("FAIL flush_ptr got %0d exp 5", ptr); end
   endtask

   task automatic test_fixed_with_ptr();
      mode_rr = 1'b0; din = 8'h88; in_valid = 1'b1; out_ready = 1'b1;
      step();
      checks++; if (out_y !== 4'd3) begin errors++; $display("FAIL fixptr_y got %0d exp 3", out_y); end
      checks++; if (ptr !== 3'd5) begin errors++; $display("FAIL fixptr_ptr got %0d exp 5", ptr); end
      mode_rr = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_y !== 4'd7) begin errors++; $display("FAIL rrptr_y got %0d exp 7", out_y); end
      checks++; if (out_onehot !== 8'h80) begin errors++; $display("FAIL rrptr_onehot got %h exp 80", out_onehot); end
      checks++; if (ptr !== 3'd0) begin errors++; $display("FAIL rrptr_ptr got %0d exp 0", ptr); end
      step();
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; mode_rr = 1'b0; in_valid = 1'b0;
      out_ready = 1'b0; din = 8'h00;
      step();
      step();
      reset = 1'b0;
      test_reset();
      test_fixed();
      test_back_to_back();
      test_rr_wrap();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_flush_mid();
      test_fixed_with_ptr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
